fetch_gshare: RTL and testbench



---
 rtl/fetch_gshare.sv | 137 +++++++++++++
 tb/tb_fetch_gshare.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_gshare.sv
// Fetch stage: PC register, two-word fetch, next-PC selection and fetch/decode pipeline register.
// Build macro GSHARE_EN selects the gshare predictor; without it, branches use static backward-taken prediction.
module fetch_gshare #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata0,
    input  logic [31:0] imem_rdata1,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [8:0]  upd_index,
    input  logic        upd_taken,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] instr1,
    output logic        prediction,
    output logic [8:0]  pc_xor_global_history
);
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0] pc_q, pc_d;
    logic        valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] instr_q;
    logic [31:0] instr1_q;
    logic        pred_q;
    logic [8:0]  idx_q;

    logic [6:0]  opcode;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] target;
    logic [8:0]  idx;
    logic        br_taken;
    logic        is_branch;
    logic        is_jal;
    logic        pred_taken;

    assign opcode    = imem_rdata0[6:0];
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign b_imm     = {{20{imem_rdata0[31]}}, imem_rdata0[7], imem_rdata0[30:25],
                        imem_rdata0[11:8], 1'b0};
    assign j_imm     = {{12{imem_rdata0[31]}}, imem_rdata0[19:12], imem_rdata0[20],
                        imem_rdata0[30:21], 1'b0};
    assign target    = pc_q + (is_jal ? j_imm : b_imm);

`ifdef GSHARE_EN
    // PHT is a flop array so it is fully cleared in the reset cycle; no sweep is needed.
    logic [8:0] ghr_q;
    logic [1:0] pht_q [512];

    assign idx      = pc_q[10:2] ^ ghr_q;
    // Reads the pre-update counter, so same-cycle training is seen from the next cycle on.
    assign br_taken = pht_q[idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
            for (int i = 0; i < 512; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[7:0], upd_taken};
            if (upd_taken && (pht_q[upd_index] != 2'b11)) begin
                pht_q[upd_index] <= pht_q[upd_index] + 2'd1;
            end else if (!upd_taken && (pht_q[upd_index] != 2'b00)) begin
                pht_q[upd_index] <= pht_q[upd_index] - 2'd1;
            end
        end
    end
`else
    logic unused_upd;

    assign idx        = pc_q[10:2];
    assign br_taken   = b_imm[31];
    assign unused_upd = ^{upd_valid, upd_index, upd_taken};
`endif

    assign pred_taken = (is_branch && br_taken) || is_jal;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (enable) begin
            pc_d = pred_taken ? target : pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Redirect squashes whatever is in flight even during a stall; pc and index are left as they were.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            out_pc_q <= '0;
            instr_q  <= NOP;
            instr1_q <= NOP;
            pred_q   <= 1'b0;
            idx_q    <= '0;
        end else if (redirect) begin
            valid_q  <= 1'b0;
            instr_q  <= NOP;
            instr1_q <= NOP;
            pred_q   <= 1'b0;
        end else if (enable) begin
            valid_q  <= 1'b1;
            out_pc_q <= pc_q;
            instr_q  <= imem_rdata0;
            instr1_q <= imem_rdata1;
            pred_q   <= pred_taken;
            idx_q    <= idx;
        end
    end

    assign imem_addr             = pc_q;
    assign valid                 = valid_q;
    assign pc                    = out_pc_q;
    assign instr                 = instr_q;
    assign instr1                = instr1_q;
    assign prediction            = pred_q;
    assign pc_xor_global_history = idx_q;
endmodule

// File: tb/tb_fetch_gshare.sv
// Bench for fetch_gshare: directed scenarios plus a randomized run against a word-level reference model.
// Gshare scenarios are compiled when GSHARE_EN is defined; static-prediction scenarios otherwise.
module tb_fetch_gshare;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_8093;
    localparam logic [31:0] JALR   = 32'h0000_80e7;
    localparam int K_ALU = 0;
    localparam int K_BR  = 1;
    localparam int K_JAL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, redirect, upd_valid, upd_taken;
    logic [31:0] redirect_pc;
    logic [8:0]  upd_index;
    logic [31:0] imem_addr, imem_rdata0, imem_rdata1;
    logic        valid, prediction;
    logic [31:0] pc, instr, instr1;
    logic [8:0]  pc_xor_global_history;

    logic [31:0] mem  [1024];
    int          kind [1024];
    int          off  [1024];
    logic [31:0] addr1;

    assign addr1       = imem_addr + 32'd4;
    assign imem_rdata0 = mem[imem_addr[11:2]];
    assign imem_rdata1 = mem[addr1[11:2]];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_gshare #(.RESET_PC(RST_PC), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .imem_addr(imem_addr), .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .valid(valid), .pc(pc), .instr(instr), .instr1(instr1),
        .prediction(prediction), .pc_xor_global_history(pc_xor_global_history)
    );

    function automatic logic [31:0] enc_b(input int o, input logic [2:0] f3);
        logic [12:0] v;
        v = o[12:0];
        return {v[12], v[10:5], 5'd2, 5'd1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int o);
        logic [20:0] v;
        v = o[20:0];
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic put_alu(input logic [31:0] a, input logic [31:0] word);
        mem[a[11:2]] = word; kind[a[11:2]] = K_ALU; off[a[11:2]] = 0;
    endtask

    task automatic put_br(input logic [31:0] a, input int o, input logic [2:0] f3);
        mem[a[11:2]] = enc_b(o, f3); kind[a[11:2]] = K_BR; off[a[11:2]] = o;
    endtask

    task automatic put_jal(input logic [31:0] a, input int o);
        mem[a[11:2]] = enc_j(o); kind[a[11:2]] = K_JAL; off[a[11:2]] = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] a);
        redirect = 1'b1; redirect_pc = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        for (int w = 0; w < 1024; w++) begin
            mem[w] = ADDI; kind[w] = K_ALU; off[w] = 0;
        end
        rst = 1'b1; enable = 1'b1; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
        tick(); tick();
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
        n_checks++; if (instr !== NOP || instr1 !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h/%h expected %h", instr, instr1, NOP); end
        n_checks++; if (prediction !== 1'b0 || pc_xor_global_history !== 9'd0) begin n_fail++; $display("FAIL reset_pred: got %b/%h expected 0/0", prediction, pc_xor_global_history); end
        rst = 1'b0;
        tick();
        n_checks++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL seq_addr1: got %h expected 104", imem_addr); end
        n_checks++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== ADDI) begin n_fail++; $display("FAIL seq_out1: got v=%b pc=%h i=%h expected 1/100/%h", valid, pc, instr, ADDI); end
        tick();
        n_checks++; if (imem_addr !== 32'h108 || pc !== 32'h104) begin n_fail++; $display("FAIL seq_addr2: got %h/%h expected 108/104", imem_addr, pc); end
        $display("test_reset done: imem_addr=%h pc=%h", imem_addr, pc);
    endtask

    task automatic test_jal();
        put_jal(32'h300, 32'h40);
        go_to(32'h300);
        n_checks++; if (imem_addr !== 32'h300 || valid !== 1'b0 || instr !== NOP) begin n_fail++; $display("FAIL jal_redirect: got %h v=%b i=%h expected 300/0/%h", imem_addr, valid, instr, NOP); end
        tick();
        n_checks++; if (imem_addr !== 32'h340 || prediction !== 1'b1 || pc !== 32'h300 || valid !== 1'b1) begin n_fail++; $display("FAIL jal_predict: got addr=%h p=%b pc=%h v=%b expected 340/1/300/1", imem_addr, prediction, pc, valid); end
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h340) begin n_fail++; $display("FAIL jal_nobubble: got v=%b pc=%h expected 1/340", valid, pc); end
        $display("test_jal done: pc=%h", pc);
    endtask

    task automatic test_redirect_stall();
        enable = 1'b0;
        go_to(32'h500);
        n_checks++; if (imem_addr !== 32'h500 || valid !== 1'b0 || instr !== 32'h13 || instr1 !== 32'h13) begin n_fail++; $display("FAIL redir_stall: got %h v=%b i=%h/%h expected 500/0/13/13", imem_addr, valid, instr, instr1); end
        tick();
        n_checks++; if (imem_addr !== 32'h500 || valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got %h v=%b expected 500/0", imem_addr, valid); end
        enable = 1'b1;
        tick();
        n_checks++; if (valid !== 1'b1 || pc !== 32'h500 || imem_addr !== 32'h504) begin n_fail++; $display("FAIL redir_arrive: got v=%b pc=%h a=%h expected 1/500/504", valid, pc, imem_addr); end
        $display("test_redirect_stall done: pc=%h", pc);
    endtask

`ifdef GSHARE_EN
    task automatic test_gshare();
        rst = 1'b1; tick(); rst = 1'b0;
        put_br(32'h200, -8, 3'b000);
        go_to(32'h200); tick();
        n_checks++; if (prediction !== 1'b0 || imem_addr !== 32'h204 || pc_xor_global_history !== 9'h080) begin n_fail++; $display("FAIL gs_cold: got p=%b a=%h i=%h expected 0/204/080", prediction, imem_addr, pc_xor_global_history); end
        for (int i = 0; i < 2; i++) begin upd_valid = 1'b1; upd_index = 9'h080; upd_taken = 1'b1; tick(); end
        for (int i = 0; i < 6; i++) begin upd_valid = 1'b1; upd_index = 9'd7; upd_taken = 1'b0; tick(); end
        for (int i = 0; i < 3; i++) begin upd_valid = 1'b1; upd_index = 9'h1FF; upd_taken = 1'b0; tick(); end
        upd_valid = 1'b0;
        go_to(32'h200); tick();
        n_checks++; if (prediction !== 1'b1 || imem_addr !== 32'h1F8 || pc_xor_global_history !== 9'h080) begin n_fail++; $display("FAIL gs_trained: got p=%b a=%h i=%h expected 1/1f8/080", prediction, imem_addr, pc_xor_global_history); end
        // counter 7 should sit at 0; one taken gives 1, then clear the GHR again
        upd_valid = 1'b1; upd_index = 9'd7; upd_taken = 1'b1; tick();
        for (int i = 0; i < 9; i++) begin upd_index = 9'h1FF; upd_taken = 1'b0; tick(); end
        upd_valid = 1'b0;
        put_br(32'h01C, -8, 3'b001);
        go_to(32'h01C);
        upd_valid = 1'b1; upd_index = 9'd7; upd_taken = 1'b1; tick();
        upd_valid = 1'b0;
        n_checks++; if (prediction !== 1'b0 || pc_xor_global_history !== 9'd7 || imem_addr !== 32'h020) begin n_fail++; $display("FAIL gs_sat_rbw: got p=%b i=%h a=%h expected 0/007/020", prediction, pc_xor_global_history, imem_addr); end
        $display("test_gshare done: idx=%h", pc_xor_global_history);
    endtask
`else
    task automatic test_static();
        put_br(32'h200, -8, 3'b001);
        go_to(32'h200); tick();
        n_checks++; if (prediction !== 1'b1 || imem_addr !== 32'h1F8 || pc_xor_global_history !== 9'h080) begin n_fail++; $display("FAIL st_back: got p=%b a=%h i=%h expected 1/1f8/080", prediction, imem_addr, pc_xor_global_history); end
        put_br(32'h400, 16, 3'b001);
        go_to(32'h400); tick();
        n_checks++; if (prediction !== 1'b0 || imem_addr !== 32'h404 || pc_xor_global_history !== 9'h100) begin n_fail++; $display("FAIL st_fwd: got p=%b a=%h i=%h expected 0/404/100", prediction, imem_addr, pc_xor_global_history); end
        upd_valid = 1'b1; upd_index = 9'h100; upd_taken = 1'b1;
        go_to(32'h400); tick(); tick();
        upd_valid = 1'b0;
        go_to(32'h400); tick();
        n_checks++; if (prediction !== 1'b0 || imem_addr !== 32'h404 || pc_xor_global_history !== 9'h100) begin n_fail++; $display("FAIL st_upd_ignored: got p=%b a=%h i=%h expected 0/404/100", prediction, imem_addr, pc_xor_global_history); end
        $display("test_static done: pred=%b", prediction);
    endtask
`endif

    // Reference model state: architectural values only, stepped once per clock.
    logic [31:0] m_pc, m_opc, m_instr, m_instr1;
    logic        m_valid, m_pred;
    int          m_idx;
`ifdef GSHARE_EN
    int m_pht [512];
    int m_ghr;
`endif

    task automatic model_reset();
        m_pc = RST_PC; m_valid = 1'b0; m_opc = '0; m_instr = NOP; m_instr1 = NOP; m_pred = 1'b0; m_idx = 0;
`ifdef GSHARE_EN
        m_ghr = 0;
        for (int i = 0; i < 512; i++) m_pht[i] = 1;
`endif
    endtask

    task automatic test_random();
        int w, w1, cur_idx, r, bad;
        logic pred;
        logic [31:0] nxt, a1;
        for (int i = 0; i < 1024; i++) begin
            r = $urandom_range(0, 19);
            if (r < 9) put_alu(32'(i * 4), ADDI);
            else if (r < 10) put_alu(32'(i * 4), JALR);
            else if (r < 16) put_br(32'(i * 4), ($urandom_range(0, 32) - 16) * 4, 3'($urandom_range(0, 7)));
            else put_jal(32'(i * 4), ($urandom_range(0, 64) - 32) * 4);
        end
        rst = 1'b1; enable = 1'b1; redirect = 1'b0; upd_valid = 1'b0;
        tick();
        model_reset();
        rst = 1'b0;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            w  = int'(m_pc[11:2]);
            a1 = m_pc + 32'd4;
            w1 = int'(a1[11:2]);
`ifdef GSHARE_EN
            cur_idx = int'(m_pc[10:2]) ^ m_ghr;
            pred = (kind[w] == K_JAL) || (kind[w] == K_BR && m_pht[cur_idx] >= 2);
`else
            cur_idx = int'(m_pc[10:2]);
            pred = (kind[w] == K_JAL) || (kind[w] == K_BR && off[w] < 0);
`endif
            nxt = pred ? m_pc + 32'(off[w]) : m_pc + 32'd4;
            rst         = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 9) < 8);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            upd_valid   = ($urandom_range(0, 2) == 0);
            upd_index   = $urandom_range(0, 1) ? 9'(cur_idx) : 9'($urandom_range(0, 511));
            upd_taken   = 1'($urandom_range(0, 1));
            if (rst) begin
                model_reset();
            end else begin
`ifdef GSHARE_EN
                if (upd_valid) begin
                    if (upd_taken) m_pht[upd_index] = (m_pht[upd_index] == 3) ? 3 : m_pht[upd_index] + 1;
                    else m_pht[upd_index] = (m_pht[upd_index] == 0) ? 0 : m_pht[upd_index] - 1;
                    m_ghr = (m_ghr * 2 + int'(upd_taken)) % 512;
                end
`endif
                if (redirect) begin
                    m_valid = 1'b0; m_instr = NOP; m_instr1 = NOP; m_pred = 1'b0; m_pc = redirect_pc;
                end else if (enable) begin
                    m_valid = 1'b1; m_opc = m_pc; m_instr = mem[w]; m_instr1 = mem[w1];
                    m_pred = pred; m_idx = cur_idx; m_pc = nxt;
                end
            end
            tick();
            n_checks++;
            if (imem_addr !== m_pc || valid !== m_valid || pc !== m_opc || instr !== m_instr ||
                instr1 !== m_instr1 || prediction !== m_pred || pc_xor_global_history !== 9'(m_idx)) begin
                n_fail++; bad++;
                if (bad <= 10) $display("FAIL rand_cycle %0d: got a=%h v=%b pc=%h i=%h i1=%h p=%b x=%h expected a=%h v=%b pc=%h i=%h i1=%h p=%b x=%h",
                    cyc, imem_addr, valid, pc, instr, instr1, prediction, pc_xor_global_history,
                    m_pc, m_valid, m_opc, m_instr, m_instr1, m_pred, 9'(m_idx));
            end
        end
        rst = 1'b0; redirect = 1'b0; upd_valid = 1'b0;
        $display("test_random done: 3000 cycles, %0d mismatching", bad);
    endtask

    initial begin
        test_reset();
        test_jal();
        test_redirect_stall();
`ifdef GSHARE_EN
        test_gshare();
`else
        test_static();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
